div_sched: RTL and testbench
============================

# div_sched

Round-robin scheduler that shares one fully pipelined, non-stallable `div` unit among `N_REQ` requesters. Each requester uses a valid/ready request handshake. The scheduler issues at most one division per cycle. It tags every issued operation with its requester ID in a shift register matched to the divider latency, and routes each quotient/remainder back to its requester as a registered one-cycle response pulse. Divide-by-zero is detected at issue and reported with fixed result values.

## Interface
- `DATA_W`, 32, operand/result width
- `N_REQ`, 4, number of requesters (2..16)
- `LATENCY`, `DATA_W`, divider latency in cycles from operand sample edge to valid result
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester grant; transfer when `req_valid[i] & req_ready[i]`
- `req_dividend`  in  N_REQ*DATA_W  flattened dividends, requester i at bits [i*DATA_W +: DATA_W]
- `req_divisor`  in  N_REQ*DATA_W  flattened divisors, same packing
- `rsp_valid`  out  N_REQ  one-cycle response pulse per requester
- `rsp_dbz`  out  1  divide-by-zero flag for the current response
- `rsp_quotient`  out  DATA_W  quotient for the pulsing requester
- `rsp_remainder`  out  DATA_W  remainder for the pulsing requester
- `div_dividend`  out  DATA_W  to divider
- `div_divisor`  out  DATA_W  to divider
- `div_quotient`  in  DATA_W  from divider
- `div_remainder`  in  DATA_W  from divider
- `idle`  out  1  high when no operation is in flight and no response is pending

## Operation
- Arbitration is combinational round-robin.
  - Pointer `last` is the index of the most recent grant.
  - Search order is `last+1`, `last+2`, … with wrap modulo N_REQ.
  - At most one `req_ready` bit is high per cycle, and only for a requester whose `req_valid` is high.
  - `req_ready` never depends on `req_ready` of other requesters.
- `last` updates to the granted index on the grant edge and holds when nothing is granted.
- On grant: `div_dividend`/`div_divisor` are driven combinationally from the granted requester's operands.
  - If the divisor is 0, the divider is driven 0/1 instead.
  - Tag entry 0 is loaded at the clock edge with {valid=1, id, dbz}.
- No grant: divider is driven dividend=0, divisor=1; tag entry 0 is loaded with valid=0.
- Tag pipe: `LATENCY` entries of {valid, id[$clog2(N_REQ)], dbz}, shifting every cycle unconditionally, matching the divider.
- Response register, loaded every cycle from the last tag entry and the divider outputs:
  - valid tag, dbz=0: `rsp_valid[id]`=1, `rsp_quotient`=`div_quotient`, `rsp_remainder`=`div_remainder`, `rsp_dbz`=0.
  - valid tag, dbz=1: `rsp_valid[id]`=1, `rsp_quotient`=all ones, `rsp_remainder`=0, `rsp_dbz`=1.
  - invalid tag: `rsp_valid`=0; data registers hold their previous value.
- There is no response backpressure. Requesters must accept the pulse.
- `idle` = no valid bit in the tag pipe and `rsp_valid`==0.

## Timing
- Throughput: one issue per cycle, sustained, regardless of requester mix.
- Latency: operands accepted at edge t produce `rsp_valid` high during cycle t+LATENCY+1, for exactly one cycle.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- Responses stay in issue order across all requesters.
- Reset values (asynchronous):
  - `rsp_valid`=0, `rsp_dbz`=0, `rsp_quotient`=0, `rsp_remainder`=0.
  - All tag valid bits 0.
  - `last`=N_REQ-1, so requester 0 wins the first arbitration.
  - `idle`=1.
- While `rst` is high: `req_ready`=0 and the divider is driven 0/1.
- Reset mid-operation: every in-flight operation is discarded and no `rsp_valid` is produced for it. Divider contents need no flush, because no tag is valid.
- Requester deasserting `req_valid` without a grant: legal; no issue occurs.
- Operand changes while ungranted: legal.
- Simultaneous grant and response for the same requester in one cycle: both occur independently.
- Pointer wrap: `last`=N_REQ-1 searches starting at 0.

## Test plan
- Single requester 2 issues 100/7 at edge t. Required: `rsp_valid`=4'b0100 only during cycle t+33 (DATA_W=32), quotient 14, remainder 2, `rsp_dbz`=0; `idle` returns to 1 afterwards.
- All 4 requesters held valid with distinct random operands for 40 cycles after reset. Required: grant sequence 0,1,2,3,0,…; every result matches a `/` and `%` reference model; every response is routed to the correct `rsp_valid` bit; no idle issue slots.
- Requester 1 issues 0xDEADBEEF/0. Required: response after LATENCY+1 cycles with `rsp_dbz`=1, quotient 0xFFFFFFFF, remainder 0; the neighbouring non-zero operation issued the next cycle returns correct results.
- Requesters 0 and 3 valid, `last`=3. Required: requester 0 is granted; then requester 3 is granted; alternation continues; requesters 1 and 2 are never granted.
- Issue 10 back-to-back operations, assert `rst` for 1 cycle at issue+15, then deassert. Required: zero `rsp_valid` pulses for those operations; a new 9/3 issued after reset returns quotient 3, remainder 0 at normal latency.
- Random valid patterns, 10k cycles, with a scoreboard. Required: per-requester response count equals grant count, each response arrives exactly LATENCY+1 cycles after its grant, and `req_ready` is never high without `req_valid`.

Source files
------------

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one pipelined, non-stallable divider among N_REQ requesters.
// Issue tags travel in a shift register matched to the divider latency and steer registered response pulses.
module div_sched #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_dividend,
  input  logic [N_REQ*DATA_W-1:0]   req_divisor,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic                      rsp_dbz,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic [DATA_W-1:0]         rsp_remainder,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic [DATA_W-1:0]         div_remainder,
  output logic                      idle
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            dbz;
  } tag_t;

  logic [ID_W-1:0]   last_q, last_d;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  int unsigned       idx;
  logic [DATA_W-1:0] sel_dividend, sel_divisor;
  logic              dbz_now;

  tag_t              tag_q [LATENCY];
  tag_t              tag_d;
  logic              inflight;

  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic              rsp_dbz_q, rsp_dbz_d;
  logic [DATA_W-1:0] rsp_quot_q, rsp_quot_d;
  logic [DATA_W-1:0] rsp_rem_q, rsp_rem_d;

  // Search starts one past the last grant and wraps; first valid hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_q) + k) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!rst && !grant_vld && (idx == i) && req_valid[i]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(i);
        end
      end
    end
    last_d = grant_vld ? grant_id : last_q;
  end

  always_comb begin
    req_ready    = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_vld && (grant_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_dividend = req_dividend[i*DATA_W +: DATA_W];
        sel_divisor  = req_divisor[i*DATA_W +: DATA_W];
      end
    end
  end

  // Zero divisors never reach the divider; the flag rides in the tag instead.
  always_comb begin
    dbz_now      = grant_vld && (sel_divisor == '0);
    div_dividend = '0;
    div_divisor  = DATA_W'(1);
    if (grant_vld && !dbz_now) begin
      div_dividend = sel_dividend;
      div_divisor  = sel_divisor;
    end
    tag_d.vld = grant_vld;
    tag_d.id  = grant_id;
    tag_d.dbz = dbz_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= ID_W'(N_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_dbz_d   = rsp_dbz_q;
    rsp_quot_d  = rsp_quot_q;
    rsp_rem_d   = rsp_rem_q;
    if (tag_q[LATENCY-1].vld) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (tag_q[LATENCY-1].id == ID_W'(i)) begin
          rsp_valid_d[i] = 1'b1;
        end
      end
      rsp_dbz_d  = tag_q[LATENCY-1].dbz;
      rsp_quot_d = tag_q[LATENCY-1].dbz ? '1 : div_quotient;
      rsp_rem_d  = tag_q[LATENCY-1].dbz ? '0 : div_remainder;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_dbz_q   <= 1'b0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_dbz_q   <= rsp_dbz_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight | tag_q[i].vld;
    end
  end

  assign idle          = !inflight && (rsp_valid_q == '0);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: pipelined divider model, schedule-based reference model, directed and random stimulus.
module tb_div_sched;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned L  = 32;
  localparam int unsigned M  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0] req_dividend, req_divisor;
  logic            rsp_dbz, idle;
  logic [DW-1:0]   rsp_quotient, rsp_remainder;
  logic [DW-1:0]   div_dividend, div_divisor, div_quotient, div_remainder;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  div_sched #(.DATA_W(DW), .N_REQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_dbz(rsp_dbz),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // External divider: L-stage pipeline, result visible L edges after sampling.
  logic [DW-1:0] pq [L];
  logic [DW-1:0] pr [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      pq[i] <= pq[i-1];
      pr[i] <= pr[i-1];
    end
    pq[0] <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
    pr[0] <= (div_divisor == 0) ? '0 : div_dividend % div_divisor;
  end
  assign div_quotient  = pq[L-1];
  assign div_remainder = pr[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int unsigned last);
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned j;
      j = (last + k) % N;
      if (v[j]) return int'(j);
    end
    return -1;
  endfunction

  // Reference model: grants schedule a response L edges later in a ring of slots.
  int unsigned   m_last, cyc;
  int            pending;
  logic          s_vld [M];
  int unsigned   s_id  [M];
  logic [DW-1:0] s_q   [M];
  logic [DW-1:0] s_r   [M];
  logic          s_dbz [M];
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_q, m_r;
  logic          m_dbz;
  int unsigned   grant_cnt [N];
  int unsigned   obs_cnt   [N];

  always @(posedge clk or posedge rst) begin
    int g;
    int unsigned sl, ns;
    logic [DW-1:0] a, b;
    if (rst) begin
      for (int i = 0; i < M; i++) s_vld[i] = 1'b0;
      pending = 0;
      m_rv    = '0;
      m_q     = '0;
      m_r     = '0;
      m_dbz   = 1'b0;
      m_last  = N - 1;
    end else begin
      cyc = cyc + 1;
      sl  = cyc % M;
      m_rv = '0;
      if (s_vld[sl]) begin
        m_rv[s_id[sl]] = 1'b1;
        m_q   = s_q[sl];
        m_r   = s_r[sl];
        m_dbz = s_dbz[sl];
        s_vld[sl] = 1'b0;
        pending--;
      end
      g = rr_pick(req_valid, m_last);
      if (g >= 0) begin
        a  = req_dividend[g*DW +: DW];
        b  = req_divisor[g*DW +: DW];
        ns = (cyc + L) % M;
        s_vld[ns] = 1'b1;
        s_id[ns]  = g;
        s_dbz[ns] = (b == 0);
        s_q[ns]   = (b == 0) ? '1 : a / b;
        s_r[ns]   = (b == 0) ? '0 : a % b;
        pending++;
        m_last = g;
        grant_cnt[g]++;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0]  er;
    logic [DW-1:0] ed, es, dv;
    g  = rst ? -1 : rr_pick(req_valid, m_last);
    er = '0;
    ed = '0;
    es = 1;
    if (g >= 0) begin
      er[g] = 1'b1;
      dv = req_divisor[g*DW +: DW];
      if (dv != 0) begin
        ed = req_dividend[g*DW +: DW];
        es = dv;
      end
    end
    chk("req_ready", req_ready, er);
    chk("ready_wo_valid", req_ready & ~req_valid, 0);
    chk("div_dividend", div_dividend, ed);
    chk("div_divisor", div_divisor, es);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_quotient", rsp_quotient, m_q);
    chk("rsp_remainder", rsp_remainder, m_r);
    chk("rsp_dbz", rsp_dbz, m_dbz);
    chk("idle", idle, (pending == 0) && (m_rv == 0));
    for (int i = 0; i < N; i++) if (rsp_valid[i]) obs_cnt[i]++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i] = v;
    req_dividend[i*DW +: DW] = a;
    req_divisor[i*DW +: DW]  = b;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned snap_o, snap_g [N], snap_ob [N];
    logic [N-1:0] exp_rr;
    logic [DW-1:0] b;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      grant_cnt[i] = 0;
      obs_cnt[i]   = 0;
    end
    rst = 1'b1;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    repeat (3) step();

    // Reset state, and no grant while reset is held.
    chk("rst_idle", idle, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_quot", rsp_quotient, 0);
    req_valid = '1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_divisor", div_divisor, 1);
    req_valid = '0;
    rst = 1'b0;

    // Single requester 2: 100 / 7.
    step();
    set_op(2, 1'b1, 100, 7);
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    step();
    set_op(2, 1'b0, 0, 0);
    repeat (L) step();
    chk("t1_valid", rsp_valid, 4'b0100);
    chk("t1_quot", rsp_quotient, 14);
    chk("t1_rem", rsp_remainder, 2);
    chk("t1_dbz", rsp_dbz, 0);
    step();
    chk("t1_valid_end", rsp_valid, 0);
    chk("t1_idle", idle, 1);

    // All four requesters valid after reset: grant order 0,1,2,3,...
    rst_pulse();
    for (int i = 0; i < N; i++) set_op(i, 1'b1, $urandom, $urandom_range(1, 1000));
    for (int k = 0; k < 40; k++) begin
      #1;
      exp_rr = N'(1) << (k % N);
      chk("rr_seq", req_ready, exp_rr);
      step();
      for (int i = 0; i < N; i++) set_op(i, 1'b1, $urandom, $urandom_range(1, 1000));
    end
    req_valid = '0;
    repeat (L + 2) step();
    chk("t2_idle", idle, 1);

    // Divide by zero followed by a normal neighbour.
    set_op(1, 1'b1, 32'hDEADBEEF, 0);
    step();
    set_op(1, 1'b0, 0, 0);
    set_op(2, 1'b1, 50, 6);
    step();
    set_op(2, 1'b0, 0, 0);
    repeat (L - 1) step();
    chk("dbz_valid", rsp_valid, 4'b0010);
    chk("dbz_flag", rsp_dbz, 1);
    chk("dbz_quot", rsp_quotient, 32'hFFFF_FFFF);
    chk("dbz_rem", rsp_remainder, 0);
    step();
    chk("nb_valid", rsp_valid, 4'b0100);
    chk("nb_quot", rsp_quotient, 8);
    chk("nb_rem", rsp_remainder, 2);
    chk("nb_dbz", rsp_dbz, 0);
    repeat (L) step();

    // Requesters 0 and 3 only, last = 3 after reset: strict alternation.
    rst_pulse();
    set_op(0, 1'b1, $urandom, $urandom_range(1, 99));
    set_op(3, 1'b1, $urandom, $urandom_range(1, 99));
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("alt_seq", req_ready, (k % 2 == 0) ? 4'b0001 : 4'b1000);
      step();
      set_op(0, 1'b1, $urandom, $urandom_range(1, 99));
      set_op(3, 1'b1, $urandom, $urandom_range(1, 99));
    end
    req_valid = '0;
    repeat (L + 2) step();

    // Ten back-to-back issues, reset mid-flight: none may respond.
    snap_o = obs_cnt[0];
    set_op(0, 1'b1, $urandom, $urandom_range(1, 50));
    for (int k = 0; k < 10; k++) begin
      step();
      set_op(0, 1'b1, $urandom, $urandom_range(1, 50));
    end
    req_valid = '0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (L + 5) step();
    chk("rst_kill", obs_cnt[0] - snap_o, 0);
    set_op(0, 1'b1, 9, 3);
    step();
    set_op(0, 1'b0, 0, 0);
    repeat (L) step();
    chk("post_rst_valid", rsp_valid, 4'b0001);
    chk("post_rst_quot", rsp_quotient, 3);
    chk("post_rst_rem", rsp_remainder, 0);
    repeat (3) step();

    // Random traffic with scoreboard.
    for (int i = 0; i < N; i++) begin
      snap_g[i]  = grant_cnt[i];
      snap_ob[i] = obs_cnt[i];
    end
    for (int k = 0; k < 10000; k++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) b = 0;
        else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
        else b = $urandom;
        req_dividend[i*DW +: DW] = $urandom;
        req_divisor[i*DW +: DW]  = b;
      end
      step();
    end
    req_valid = '0;
    repeat (L + 3) step();
    chk("rand_idle", idle, 1);
    for (int i = 0; i < N; i++) begin
      chk("rand_count", obs_cnt[i] - snap_ob[i], grant_cnt[i] - snap_g[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
